// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: req/ack handshake to a variable-latency data
// memory, store lane replication, load extraction/extension and a watchdog.
module lsu_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [1:0]  lwhb,
  input  logic [1:0]  swhb,
  input  logic        lunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] W_WORD = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_BYTE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t state_q, state_d;

  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [3:0]     mem_be_q, mem_be_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic           mem_we_q, mem_we_d;
  logic           ld_q, ld_d;
  logic [1:0]     lwidth_q, lwidth_d;
  logic           uns_q, uns_d;
  logic [1:0]     lane_q, lane_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           rdata_valid_q, rdata_valid_d;
  logic           bus_err_q, bus_err_d;

  logic        acc, is_st, aligned, go, expired;
  logic [1:0]  width;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode of the instruction currently sitting in MEM; only used in IDLE.
  always_comb begin
    acc     = valid_i & (memwrite | memtoreg);
    is_st   = memwrite;
    width   = is_st ? swhb : lwhb;
    aligned = 1'b1;
    if (width == W_WORD) aligned = (addr[1:0] == 2'b00);
    if (width == W_HALF) aligned = ~addr[0];
    go      = acc & aligned & (width != 2'b00);
    expired = (wdog_q == WDW'(TIMEOUT - 1));
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lwidth_q)
      W_BYTE:  ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      W_HALF:  ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; ack wins over a watchdog expiring in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_REQ;
      S_REQ:   if (mem_ack || expired) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_req    = (state_q == S_REQ);
    stall_o    = (state_q == S_REQ) | ((state_q == S_IDLE) & go);
    misalign_o = (state_q == S_IDLE) & acc & (width != 2'b00) & ~aligned;
  end

  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = mem_we_q;
    ld_d          = ld_q;
    lwidth_d      = lwidth_q;
    uns_d         = uns_q;
    lane_d        = lane_q;
    wdog_d        = wdog_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
    if (state_q == S_IDLE && go) begin
      mem_addr_d = {addr[31:2], 2'b00};
      case (width)
        W_BYTE: begin
          mem_be_d    = 4'b0001 << addr[1:0];
          mem_wdata_d = {4{wdata[7:0]}};
        end
        W_HALF: begin
          mem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata_d = {2{wdata[15:0]}};
        end
        default: begin
          mem_be_d    = 4'b1111;
          mem_wdata_d = wdata;
        end
      endcase
      mem_we_d = is_st;
      ld_d     = ~is_st;
      lwidth_d = width;
      uns_d    = lunsigned;
      lane_d   = addr[1:0];
      wdog_d   = '0;
    end else if (state_q == S_REQ) begin
      if (mem_ack) begin
        if (ld_q) rdata_d = ld_ext;
        rdata_valid_d = ld_q;
      end else begin
        wdog_d    = wdog_q + 1'b1;
        bus_err_d = expired;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      ld_q          <= 1'b0;
      lwidth_q      <= '0;
      uns_q         <= 1'b0;
      lane_q        <= '0;
      wdog_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      ld_q          <= ld_d;
      lwidth_q      <= lwidth_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      wdog_q        <= wdog_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Random + directed bench for lsu_mem_stage against a transaction-level model.
module tb_lsu_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, memwrite, memtoreg, lunsigned;
  logic [1:0]  lwhb, swhb;
  logic [31:0] addr, wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_o, rdata_valid_o, misalign_o, bus_err_o;
  logic [31:0] rdata_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = '0;

  lsu_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .memwrite(memwrite),
    .memtoreg(memtoreg), .lwhb(lwhb), .swhb(swhb), .lunsigned(lunsigned),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_o(stall_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MEM instruction. w: 01 word, 10 half, 11 byte. dly: REQ cycles before
  // the ack; dly >= TO means the memory never answers.
  task automatic do_access(input bit st, input bit both, input logic [1:0] w,
                           input bit uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly);
    bit mis, fin, ok;
    int nreq, sh;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
    @(negedge clk);
    valid_i   = 1'b1;
    memwrite  = st;
    memtoreg  = !st || both;
    swhb      = st ? w : 2'($urandom);
    lwhb      = st ? 2'($urandom) : w;
    lunsigned = uns;
    addr      = a;
    wdata     = wd;
    mem_ack   = 1'b0;
    #1;
    mis = (w == 2'b01 && a % 4 != 0) || (w == 2'b10 && a % 2 != 0);
    if (w == 2'b00 || mis) begin
      chk("stall_noacc", stall_o, 0);
      chk("misalign", misalign_o, mis);
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      chk("noreq", mem_req, 0);
      chk("misalign_clr", misalign_o, 0);
      chk("rdata_keep", rdata_o, exp_rdata);
      return;
    end
    chk("stall_launch", stall_o, 1);
    chk("misalign_none", misalign_o, 0);
    case (w)
      2'b11: begin ebe = 4'(1 << (a % 4)); ewd = {4{wd[7:0]}}; end
      2'b10: begin ebe = (a % 4 >= 2) ? 4'hC : 4'h3; ewd = {2{wd[15:0]}}; end
      default: begin ebe = 4'hF; ewd = wd; end
    endcase
    case (w)
      2'b11: begin
        sh  = 8 * int'(a % 4);
        erd = (rd >> sh) & 32'hFF;
        if (!uns && erd >= 32'h80) erd = erd + 32'hFFFF_FF00;
      end
      2'b10: begin
        sh  = (a % 4 >= 2) ? 16 : 0;
        erd = (rd >> sh) & 32'hFFFF;
        if (!uns && erd >= 32'h8000) erd = erd + 32'hFFFF_0000;
      end
      default: erd = rd;
    endcase
    ok = (dly < TO);
    nreq = 0;
    fin = 0;
    for (int c = 0; c < TO + 4; c++) begin
      @(negedge clk);
      if (!mem_req) begin fin = 1; break; end
      nreq++;
      chk("req_stall", stall_o, 1);
      chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("req_be", mem_be, ebe);
      chk("req_we", mem_we, st);
      if (st) chk("req_wdata", mem_wdata, ewd);
      mem_ack   = (nreq - 1 == dly);
      mem_rdata = mem_ack ? rd : $urandom;
    end
    if (!fin) begin
      chk("resp_reached", mem_req, 0);
      return;
    end
    #1;
    chk("req_cycles", nreq, ok ? dly + 1 : TO);
    chk("resp_stall", stall_o, 0);
    chk("resp_valid", rdata_valid_o, ok && !st);
    chk("resp_buserr", bus_err_o, !ok);
    if (ok && !st) exp_rdata = erd;
    chk("resp_rdata", rdata_o, exp_rdata);
    // A stray ack after an abort must be dropped.
    mem_ack   = !ok;
    mem_rdata = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_i = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("idle_noreq", mem_req, 0);
    chk("idle_rdata", rdata_o, exp_rdata);
    chk("idle_noflags", {rdata_valid_o, bus_err_o, stall_o}, 0);
  endtask

  initial begin
    reset = 1'b0; valid_i = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
    lwhb = 2'b00; swhb = 2'b00; lunsigned = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_bus", {mem_we, mem_be, mem_addr, mem_wdata} != 0, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_flags", {rdata_valid_o, bus_err_o, stall_o, misalign_o}, 0);
    reset = 1'b1;

    do_access(1, 0, 2'b11, 0, 32'h103, 32'h0000_00AB, 32'h0, 0);
    do_access(0, 0, 2'b10, 0, 32'h202, 32'h0, 32'h8001_1234, 0);
    chk("lh", rdata_o, 32'hFFFF_8001);
    do_access(0, 0, 2'b10, 1, 32'h202, 32'h0, 32'h8001_1234, 1);
    chk("lhu", rdata_o, 32'h0000_8001);
    do_access(0, 0, 2'b11, 1, 32'h201, 32'h0, 32'h8001_1234, 0);
    chk("lbu", rdata_o, 32'h0000_0012);
    do_access(0, 0, 2'b01, 0, 32'h206, 32'h0, 32'h0, 0);
    do_access(0, 0, 2'b01, 0, 32'h300, 32'h0, 32'hDEAD_BEEF, 2);
    chk("lw_delay", rdata_o, 32'hDEAD_BEEF);
    do_access(0, 0, 2'b01, 0, 32'h400, 32'h0, 32'h1111_2222, TO);
    do_access(0, 0, 2'b01, 0, 32'h404, 32'h0, 32'h3333_4444, 1);
    chk("after_abort", rdata_o, 32'h3333_4444);
    idle_cycle();

    // Reset during the second REQ cycle abandons the request.
    @(negedge clk);
    valid_i = 1'b1; memwrite = 1'b0; memtoreg = 1'b1; lwhb = 2'b01;
    addr = 32'h500; mem_ack = 1'b0;
    @(negedge clk);
    chk("rstreq_req1", mem_req, 1);
    @(negedge clk);
    chk("rstreq_req2", mem_req, 1);
    reset = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstreq_req", mem_req, 0);
    chk("rstreq_bus", {mem_we, mem_be, mem_addr, mem_wdata} != 0, 0);
    chk("rstreq_rdata", rdata_o, 0);
    chk("rstreq_flags", {rdata_valid_o, bus_err_o, stall_o}, 0);
    exp_rdata = '0;

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  w;
      logic [31:0] a;
      w = 2'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'b01) a[1:0] = 2'b00;
        if (w == 2'b10) a[0] = 1'b0;
      end
      do_access(1'($urandom), 1'($urandom), w, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, TO));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
